wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter for the pipelined core; the sole driver of the register file write port (WE3/A3/WD3).
- Merges two result sources:
  - single-cycle ALU results from the MEM/WB pipeline register;
  - variable-latency load results from the data-memory unit.
- Load results that lose arbitration wait in a small FIFO.
- Publishes a pending-register mask so the hazard unit can stall readers of registers with queued loads.

Parameters:
DEPTH, 4, load-result FIFO entries (power of two, >=2)
STARVE_LIMIT, 3, consecutive cycles a queued load may lose to the ALU before the ALU is blocked

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
ld_valid  input  1  load result offered
ld_ready  output  1  load result accepted this cycle
ld_rd  input  5  load destination register
ld_data  input  32  load data
WE3  output  1  register file write enable
A3  output  5  register file write address
WD3  output  32  register file write data
pend_mask  output  32  bit n set while a load to xn is queued or on the write port
fifo_cnt  output  3  queued load entries (width clog2(DEPTH)+1)

Behaviour:
- Reset (rst=0, async): WE3=0, A3=0, WD3=0, FIFO empty, starve counter 0. alu_ready=0, ld_ready=0, pend_mask=0 while rst=0.
- Handshake: a transfer occurs when valid&&ready at a rising edge. Sources hold rd/data stable while valid&&!ready.
- ld_ready = rst && !(FIFO full). It does not depend on ld_valid.
- alu_ready = rst && !starve, where starve = (starve_cnt >= STARVE_LIMIT) && FIFO non-empty.
- Each edge, exactly one winner is registered into WE3/A3/WD3. Priority:
  1. FIFO head, if starve;
  2. ALU, if alu_valid && alu_ready;
  3. FIFO head, if non-empty;
  4. incoming load, if FIFO empty and ld_valid (bypass, not enqueued);
  5. none, WE3=0.
- An accepted load that is not the winner is enqueued.
- Same-edge pop+push on a full FIFO is not permitted; ld_ready is already low when full.
- Latency: accepted result -> WE3 high the next cycle -> register file updated at the following edge.
- Writes with rd=0 are accepted and consume the slot but drive WE3=0. A3/WD3 still update.
- Starve counter:
  - increments when the FIFO is non-empty and the ALU wins;
  - clears when the head is popped or the FIFO is empty;
  - saturates at STARVE_LIMIT.
- FIFO: circular, log2(DEPTH)-bit pointers wrapping modulo DEPTH. fifo_cnt counts 0..DEPTH.
- Ordering: loads retire in acceptance order. Two queued entries with the same rd write in FIFO order, so the last value wins.
- pend_mask:
  - combinational OR of one-hot(rd) over valid FIFO entries, plus one-hot(A3) while the current WE3 comes from a load;
  - bit 0 is always 0;
  - a bit stays set until its last queued entry has written.
- Async reset mid-operation discards queued loads; no partial write occurs.

Test Plan:
- Reset: rst=0 with ld_valid=1 -> WE3=0, ld_ready=0, pend_mask=0. Release -> ld_ready=1, fifo_cnt=0.
- Bypass: FIFO empty, ld (rd=5, 0x1234) only -> next cycle WE3=1, A3=5, WD3=0x1234; pend_mask[5]=1 for that one cycle.
- Conflict: ALU (rd=3, 0xA) and load (rd=7, 0xB) in the same cycle:
  - -> WE3 A3=3 first, then A3=7 the next cycle;
  - fifo_cnt goes 1 then 0; pend_mask[7] is set for two cycles.
- Starvation (STARVE_LIMIT=3): ALU valid every cycle with one queued load -> ALU wins 3 times, alu_ready=0 on the 4th cycle, the load writes, then alu_ready=1.
- Full:
  - -> with alu_valid held, 4 loads fill the FIFO; fifo_cnt=4, ld_ready=0, and a 5th ld_valid is held off;
  - -> releasing ALU drains the FIFO in order with pointer wrap;
  - -> rd=0 entries give WE3=0.
- Duplicate rd: two loads to x9 (0x1, 0x2) queued -> pend_mask[9] stays set until the second write; the final WD3 to A3=9 is 0x2.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file write port.
// Losing loads queue in a small FIFO; pend_mask exposes registers with outstanding loads.
module wb_arbiter #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [4:0]               alu_rd,
   input  logic [31:0]              alu_data,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [4:0]               ld_rd,
   input  logic [31:0]              ld_data,
   output logic                     WE3,
   output logic [4:0]               A3,
   output logic [31:0]              WD3,
   output logic [31:0]              pend_mask,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    q_rd   [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic [SW-1:0] starve_cnt;
   logic          wb_ld;

   logic        empty;
   logic        full;
   logic        starve;
   logic        alu_fire;
   logic        ld_fire;
   logic        pop;
   logic        push;
   logic        win;
   logic        win_ld;
   logic        alu_win;
   logic [4:0]  win_rd;
   logic [31:0] win_data;

   assign empty     = (cnt == '0);
   assign full      = (cnt == CW'(DEPTH));
   assign starve    = (starve_cnt >= SW'(STARVE_LIMIT)) && !empty;
   assign alu_ready = rst && !starve;
   assign ld_ready  = rst && !full;
   assign alu_fire  = alu_valid && alu_ready;
   assign ld_fire   = ld_valid && ld_ready;
   assign fifo_cnt  = cnt;

   // Winner selection: starved head, ALU, queued head, then load bypass
   always_comb begin
      pop      = 1'b0;
      win      = 1'b0;
      win_ld   = 1'b0;
      alu_win  = 1'b0;
      win_rd   = '0;
      win_data = '0;
      if (starve) begin
         pop      = 1'b1;
         win      = 1'b1;
         win_ld   = 1'b1;
         win_rd   = q_rd[rd_ptr];
         win_data = q_data[rd_ptr];
      end else if (alu_fire) begin
         win      = 1'b1;
         alu_win  = 1'b1;
         win_rd   = alu_rd;
         win_data = alu_data;
      end else if (!empty) begin
         pop      = 1'b1;
         win      = 1'b1;
         win_ld   = 1'b1;
         win_rd   = q_rd[rd_ptr];
         win_data = q_data[rd_ptr];
      end else if (ld_fire) begin
         win      = 1'b1;
         win_ld   = 1'b1;
         win_rd   = ld_rd;
         win_data = ld_data;
      end
      push = ld_fire && !(win_ld && !pop);
   end

   // Pending-register mask over queued entries plus a load currently on the port
   always_comb begin
      logic [PW-1:0] idx;
      pend_mask = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < cnt) pend_mask[q_rd[idx]] = 1'b1;
      end
      if (WE3 && wb_ld) pend_mask[A3] = 1'b1;
      pend_mask[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= ld_rd;
         q_data[wr_ptr] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         starve_cnt <= '0;
         WE3        <= 1'b0;
         A3         <= '0;
         WD3        <= '0;
         wb_ld      <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr + PW'(pop);
         wr_ptr <= wr_ptr + PW'(push);
         cnt    <= cnt + CW'(push) - CW'(pop);
         if (empty || pop)
            starve_cnt <= '0;
         else if (alu_win && (starve_cnt != SW'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + SW'(1);
         WE3   <= win && (win_rd != 5'd0);
         wb_ld <= win && win_ld;
         if (win) begin
            A3  <= win_rd;
            WD3 <= win_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a queue-based writeback model.
module tb_wb_arbiter;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, ld_valid, ld_ready;
   logic [4:0]  alu_rd, ld_rd, A3;
   logic [31:0] alu_data, ld_data, WD3, pend_mask;
   logic        WE3;
   logic [2:0]  fifo_cnt;

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .WE3(WE3), .A3(A3), .WD3(WD3), .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
   typedef struct packed {
      logic alu_rdy; logic ld_rdy; logic [2:0] cnt; logic [31:0] pend;
      logic we; logic [4:0] a3; logic [31:0] wd;
   } rec_t;

   ent_t mq[$];
   rec_t exp_q[$];
   int          msc;
   logic        m_we, m_from_ld, m_alu_rdy, m_ld_rdy;
   logic [4:0]  m_a3;
   logic [31:0] m_wd;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      msc = 0; m_we = 1'b0; m_from_ld = 1'b0; m_a3 = '0; m_wd = '0;
      m_alu_rdy = 1'b1; m_ld_rdy = 1'b1;
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] m = '0;
      foreach (mq[i]) m[mq[i].rd] = 1'b1;
      if (m_we && m_from_ld) m[m_a3] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   // One cycle: drive inputs, publish expectations, advance the model across the edge
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      bit   empty, full, starve, af, lf, won, popped, bypass, alu_won;
      ent_t w;
      rec_t r;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      ld_valid = lv; ld_rd = lrd; ld_data = ld;
      empty  = (mq.size() == 0);
      full   = (mq.size() == DEPTH);
      starve = (msc >= LIMIT) && !empty;
      m_alu_rdy = !starve;
      m_ld_rdy  = !full;
      r = '{alu_rdy: m_alu_rdy, ld_rdy: m_ld_rdy, cnt: 3'(mq.size()), pend: model_pend(),
            we: m_we, a3: m_a3, wd: m_wd};
      exp_q.push_back(r);
      af = av && m_alu_rdy;
      lf = lv && m_ld_rdy;
      won = 1'b1; popped = 1'b0; bypass = 1'b0; alu_won = 1'b0;
      w = '{rd: ard, d: ad};
      if (starve || (!af && !empty)) begin
         w = mq.pop_front(); popped = 1'b1;
      end else if (af) begin
         alu_won = 1'b1;
      end else if (lf) begin
         w = '{rd: lrd, d: ld}; bypass = 1'b1;
      end else begin
         won = 1'b0;
      end
      if (lf && !bypass) mq.push_back('{rd: lrd, d: ld});
      if (empty || popped) msc = 0;
      else if (alu_won && msc < LIMIT) msc++;
      m_we      = won && (w.rd != 5'd0);
      m_from_ld = won && !alu_won;
      if (won) begin m_a3 = w.rd; m_wd = w.d; end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   always @(negedge clk) begin
      rec_t r;
      if (mon_en && rst && exp_q.size() != 0) begin
         r = exp_q.pop_front();
         chk("alu_ready", 32'(alu_ready), 32'(r.alu_rdy));
         chk("ld_ready", 32'(ld_ready), 32'(r.ld_rdy));
         chk("fifo_cnt", 32'(fifo_cnt), 32'(r.cnt));
         chk("pend_mask", pend_mask, r.pend);
         chk("WE3", 32'(WE3), 32'(r.we));
         chk("A3", 32'(A3), 32'(r.a3));
         chk("WD3", WD3, r.wd);
      end
   end

   initial begin
      logic        rav, rlv;
      logic [4:0]  rard, rlrd;
      logic [31:0] rad, rld;
      int          pa, pl;
      rst = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h55;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_WE3", 32'(WE3), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_alu_ready", 32'(alu_ready), 32'd0);
      chk("rst_pend_mask", pend_mask, 32'd0);
      ld_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rel_ld_ready", 32'(ld_ready), 32'd1);
      chk("rel_fifo_cnt", 32'(fifo_cnt), 32'd0);
      mon_en = 1'b1;

      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
      chk("byp_WE3", 32'(WE3), 32'd1);
      chk("byp_A3", 32'(A3), 32'd5);
      chk("byp_WD3", WD3, 32'h1234);
      chk("byp_pend5", 32'(pend_mask[5]), 32'd1);
      idle(2);

      step(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
      idle(3);

      step(1'b1, 5'd3, 32'h3, 1'b1, 5'd8, 32'h8);
      repeat (6) step(1'b1, 5'd4, 32'hC0DE, 1'b0, 5'd0, 32'd0);
      idle(3);

      step(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h1);
      step(1'b1, 5'd1, 32'h12, 1'b1, 5'd0, 32'hDEAD);
      step(1'b1, 5'd1, 32'h13, 1'b1, 5'd9, 32'h2);
      step(1'b1, 5'd1, 32'h14, 1'b1, 5'd12, 32'hC);
      chk("full_cnt", 32'(fifo_cnt), 32'd4);
      chk("full_ld_ready", 32'(ld_ready), 32'd0);
      step(1'b1, 5'd1, 32'h15, 1'b1, 5'd13, 32'hD);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD);
      idle(7);

      rav = 1'b0; rlv = 1'b0; rard = '0; rlrd = '0; rad = '0; rld = '0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            step(1'b1, 5'd2, 32'h2, 1'b1, 5'd6, 32'h6);
            step(1'b1, 5'd2, 32'h2, 1'b1, 5'd6, 32'h7);
            rst = 1'b0;
            #1;
            chk("mid_WE3", 32'(WE3), 32'd0);
            chk("mid_fifo_cnt", 32'(fifo_cnt), 32'd0);
            chk("mid_pend_mask", pend_mask, 32'd0);
            chk("mid_alu_ready", 32'(alu_ready), 32'd0);
            chk("mid_ld_ready", 32'(ld_ready), 32'd0);
            alu_valid = 1'b0; ld_valid = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            model_reset();
            rav = 1'b0; rlv = 1'b0;
         end
         pa = ((i / 200) % 3 == 0) ? 90 : ((i / 200) % 3 == 1) ? 40 : 70;
         pl = ((i / 150) % 2 == 0) ? 80 : 35;
         if (!(rav && !m_alu_rdy)) begin
            rav  = ($urandom_range(0, 99) < pa);
            rard = 5'($urandom_range(0, 15));
            rad  = $urandom;
         end
         if (!(rlv && !m_ld_rdy)) begin
            rlv  = ($urandom_range(0, 99) < pl);
            rlrd = 5'($urandom_range(0, 15));
            rld  = $urandom;
         end
         step(rav, rard, rad, rlv, rlrd, rld);
      end
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
